// File: rtl/spi_rx_pkg.sv
// Purpose : shared types and width helpers for the SPI packet receiver.
// Latency : n/a (package, no logic).
// Backpressure: n/a.
// Contents: FSM state enum, default widths, clog2 and counter-width helpers.
package spi_rx_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

  // Bit counter must hold 0..PACKET_W+1 so an over-long frame stays visible.
  function automatic int cnt_width(input int packet_w);
    return clog2(packet_w + 2);
  endfunction

endpackage

// File: rtl/spi_packet_rx_if.sv
// Purpose : bundles the SPI pins and the channel/commit outputs of spi_packet_rx.
// Latency : n/a (wiring only).
// Backpressure: none; commit outputs are pulses, host paces frames.
// Modports: master = host/consumer side, slave = receiver side.
interface spi_packet_rx_if
  import spi_rx_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH
);

  logic                     cs;
  logic                     sck;
  logic                     sdi;
  logic                     sdo;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     wr_valid;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     frame_err;
  logic                     addr_err;

  modport master (
    output cs, sck, sdi,
    input  sdo, ch_data, wr_valid, wr_addr, wr_data, frame_err, addr_err
  );

  modport slave (
    input  cs, sck, sdi,
    output sdo, ch_data, wr_valid, wr_addr, wr_data, frame_err, addr_err
  );

endinterface

// File: rtl/spi_packet_rx_sync_edge.sv
// Purpose : 2-flop synchroniser with optional rise/fall pulses from a third flop.
// Latency : q follows d after 2 clk edges; rise/fall pulse in the same cycle q changes.
// Backpressure: none.
// Ports: clk, reset (sync, active-low), d (async in), q (synced), rise/fall (1-cycle pulses).
module sync_edge #(
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  if (EDGE_EN) begin : g_edge
    logic s3;
    always_ff @(posedge clk) begin
      if (!reset) s3 <= 1'b0;
      else        s3 <= s2;
    end
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;
  end else begin : g_no_edge
    assign rise = 1'b0;
    assign fall = 1'b0;
  end

endmodule

// File: rtl/spi_packet_rx.sv
// Purpose : SPI slave that shifts in {addr,data} packets and commits data to NUM_CH channel regs.
// Latency : commit pulses and channel update land on the 3rd clk edge that samples cs low.
// Backpressure: none; host must keep sck phases >= 2 clk and leave a gap after cs falls.
// Ports: clk, reset (sync, active-low), bus (spi_packet_rx_if.slave: cs/sck/sdi in;
//        sdo, ch_data, wr_valid, wr_addr, wr_data, frame_err, addr_err out).
// Build option: define SPI_READBACK_EN to shift the addressed channel's old value out on sdo.
module spi_packet_rx
  import spi_rx_pkg::*;
#(
  parameter int              ADDR_W   = DEF_ADDR_W,
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              NUM_CH   = DEF_NUM_CH,
  parameter logic [DATA_W-1:0] CH_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  spi_packet_rx_if.slave  bus
);

  localparam int PACKET_W = ADDR_W + DATA_W;
  localparam int CNT_W    = cnt_width(PACKET_W);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(PACKET_W);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(PACKET_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ADDR  = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   NUM_CH_X  = (ADDR_W + 1)'(NUM_CH);

  logic cs_q, cs_rise, cs_fall;
  logic sck_q, sck_rise, sck_fall;
  logic sdi_q, sdi_rise, sdi_fall;

  sync_edge #(.EDGE_EN(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(bus.cs), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  sync_edge #(.EDGE_EN(1'b1)) u_sck (
    .clk(clk), .reset(reset), .d(bus.sck), .q(sck_q), .rise(sck_rise), .fall(sck_fall)
  );
  sync_edge #(.EDGE_EN(1'b0)) u_sdi (
    .clk(clk), .reset(reset), .d(bus.sdi), .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall)
  );

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [PACKET_W-1:0] sh;
  logic [DATA_W-1:0]   ch [NUM_CH];
  logic                wr_valid_reg;
  logic                frame_err_reg;
  logic                addr_err_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [DATA_W-1:0]   wr_data_reg;
  // After reset the synchroniser holds reset zeros, not samples; prime counts
  // until every stage holds a real sample, and armed then waits for a genuine
  // low on cs so a cs already high at release never looks like a new frame.
  logic [1:0]          prime;
  logic                armed;

  logic [ADDR_W-1:0]   pkt_addr;
  logic [DATA_W-1:0]   pkt_data;
  logic                addr_ok;

  assign pkt_addr = sh[PACKET_W-1 -: ADDR_W];
  assign pkt_data = sh[DATA_W-1:0];
  assign addr_ok  = {1'b0, pkt_addr} < NUM_CH_X;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      sh            <= '0;
      wr_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      addr_err_reg  <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      prime         <= '0;
      armed         <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ch[i] <= CH_RESET;
    end else begin
      wr_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      addr_err_reg  <= 1'b0;
      if (prime != 2'd3) prime <= prime + 2'd1;
      if (prime == 2'd3 && !cs_q) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (cs_rise && armed) begin
            state <= ST_SHIFT;
            cnt   <= '0;
            sh    <= '0;
          end
        end
        ST_SHIFT: begin
          // Frame end wins over a coincident sck edge; the commit result is
          // registered here so it is visible during the COMMIT cycle.
          if (cs_fall) begin
            state       <= ST_COMMIT;
            wr_addr_reg <= pkt_addr;
            wr_data_reg <= pkt_data;
            if (cnt != CNT_FULL) begin
              frame_err_reg <= 1'b1;
            end else if (!addr_ok) begin
              addr_err_reg <= 1'b1;
            end else begin
              wr_valid_reg <= 1'b1;
              for (int i = 0; i < NUM_CH; i++) begin
                if ({1'b0, pkt_addr} == (ADDR_W + 1)'(i)) ch[i] <= pkt_data;
              end
            end
          end else if (sck_rise) begin
            sh <= {sh[PACKET_W-2:0], sdi_q};
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign bus.ch_data[g*DATA_W +: DATA_W] = ch[g];
  end

  assign bus.wr_valid  = wr_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.addr_err  = addr_err_reg;
  assign bus.wr_addr   = wr_addr_reg;
  assign bus.wr_data   = wr_data_reg;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] rb_sh;
  logic [DATA_W-1:0] rb_sel;

  // While cnt == ADDR_W the low bits of sh are exactly the address field.
  always_comb begin
    rb_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ({1'b0, sh[ADDR_W-1:0]} == (ADDR_W + 1)'(i)) rb_sel = ch[i];
    end
  end

  // Load on the sck fall that follows the last address bit so the MSB is
  // stable before the first data-bit rising edge; later falls advance it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rb_sh <= '0;
    end else if (state != ST_SHIFT) begin
      rb_sh <= '0;
    end else if (sck_fall) begin
      if (cnt == CNT_ADDR) rb_sh <= rb_sel;
      else                 rb_sh <= {rb_sh[DATA_W-2:0], 1'b0};
    end
  end

  assign bus.sdo = (state == ST_SHIFT) ? rb_sh[DATA_W-1] : 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sck_q, sdi_rise, sdi_fall};
`else
  assign bus.sdo = 1'b0;

  logic unused_sync;
  assign unused_sync = ^{sck_q, sck_fall, sdi_rise, sdi_fall};
`endif

endmodule

// File: tb/tb_spi_packet_rx.sv
// Purpose : directed self-checking bench for spi_packet_rx (ADDR_W=8, DATA_W=16, NUM_CH=4).
// Latency : expects commit pulses exactly 3 clk after cs is driven low.
// Backpressure: n/a; host timing is 4 clk per sck phase.
module tb_spi_packet_rx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  spi_packet_rx_if bus_if ();

  spi_packet_rx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int errors = 0;
  int checks = 0;
  logic [15:0] sdo_cap;
  logic [31:0] pkt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Raise cs and clock out the low nbits of val MSB first; cs stays high.
  // sdo is sampled just before each rising edge of the last 16 bits.
  task automatic send_bits(input logic [31:0] val, input int nbits);
    bus_if.cs = 1'b1;
    repeat (4) @(negedge clk);
    sdo_cap = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      bus_if.sdi = val[i];
      repeat (4) @(negedge clk);
      if (i < 16) sdo_cap[i] = bus_if.sdo;
      bus_if.sck = 1'b1;
      repeat (4) @(negedge clk);
      bus_if.sck = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // Drop cs and watch 6 cycles: count each pulse and note when the first lands.
  task automatic end_frame(input string tag, input int ev, input int ef, input int ea);
    int nv, nf, na, at;
    nv = 0; nf = 0; na = 0; at = 0;
    bus_if.cs = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus_if.wr_valid)  nv++;
      if (bus_if.frame_err) nf++;
      if (bus_if.addr_err)  na++;
      if ((bus_if.wr_valid || bus_if.frame_err || bus_if.addr_err) && at == 0) at = k;
    end
    check({tag, " wr_valid pulses"}, 64'(nv), 64'(ev));
    check({tag, " frame_err pulses"}, 64'(nf), 64'(ef));
    check({tag, " addr_err pulses"}, 64'(na), 64'(ea));
    check({tag, " pulse cycle"}, 64'(at), (ev + ef + ea > 0) ? 64'd3 : 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ch_data"}, bus_if.ch_data, 64'h0);
    check({tag, " wr_valid"}, 64'(bus_if.wr_valid), 64'h0);
    check({tag, " frame_err"}, 64'(bus_if.frame_err), 64'h0);
    check({tag, " addr_err"}, 64'(bus_if.addr_err), 64'h0);
    check({tag, " wr_addr"}, 64'(bus_if.wr_addr), 64'h0);
    check({tag, " wr_data"}, 64'(bus_if.wr_data), 64'h0);
    check({tag, " sdo"}, 64'(bus_if.sdo), 64'h0);
  endtask

  initial begin
    bus_if.cs  = 1'b0;
    bus_if.sck = 1'b0;
    bus_if.sdi = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Legal write to ch1.
    send_bits(32'h0114FF, 24);
    end_frame("ch1 write", 1, 0, 0);
    check("ch1 wr_addr", 64'(bus_if.wr_addr), 64'h01);
    check("ch1 wr_data", 64'(bus_if.wr_data), 64'h14FF);
    check("ch1 ch_data", bus_if.ch_data, 64'h0000_0000_14FF_0000);

    // Address 3 is the highest legal channel with NUM_CH=4.
    send_bits(32'h0314FF, 24);
    end_frame("ch3 write", 1, 0, 0);
    check("ch3 wr_addr", 64'(bus_if.wr_addr), 64'h03);
    check("ch3 ch_data", bus_if.ch_data, 64'h14FF_0000_14FF_0000);

    // First illegal address.
    send_bits(32'h0414FF, 24);
    end_frame("addr4", 0, 0, 1);
    check("addr4 wr_addr", 64'(bus_if.wr_addr), 64'h04);
    check("addr4 wr_data", 64'(bus_if.wr_data), 64'h14FF);
    check("addr4 ch_data", bus_if.ch_data, 64'h14FF_0000_14FF_0000);

    // Short frame: shift reg holds 24'h012345 but nothing is written.
    send_bits(32'h012345, 23);
    end_frame("short", 0, 1, 0);
    check("short wr_addr", 64'(bus_if.wr_addr), 64'h01);
    check("short wr_data", 64'(bus_if.wr_data), 64'h2345);
    check("short ch_data", bus_if.ch_data, 64'h14FF_0000_14FF_0000);

    // Long frame: last 24 bits form a legal packet, still rejected on length.
    send_bits(32'h0100ABCD, 25);
    end_frame("long", 0, 1, 0);
    check("long wr_addr", 64'(bus_if.wr_addr), 64'h00);
    check("long wr_data", 64'(bus_if.wr_data), 64'hABCD);
    check("long ch_data", bus_if.ch_data, 64'h14FF_0000_14FF_0000);

    send_bits(32'h00ABCD, 24);
    end_frame("ch0 write", 1, 0, 0);
    check("ch0 ch_data", bus_if.ch_data, 64'h14FF_0000_14FF_ABCD);

    // Zero-bit frame.
    send_bits(32'h0, 0);
    end_frame("empty", 0, 1, 0);
    check("empty wr_addr", 64'(bus_if.wr_addr), 64'h00);
    check("empty wr_data", 64'(bus_if.wr_data), 64'h0000);

    // Reset mid-frame with cs held high through release.
    pkt = 32'h02BEEF;
    send_bits(pkt >> 14, 10);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("mid reset");
    reset = 1'b1;
    send_bits(pkt & 32'h3FFF, 14);
    end_frame("post-reset tail", 0, 0, 0);
    check("tail ch_data", bus_if.ch_data, 64'h0);
    send_bits(pkt, 24);
    end_frame("ch2 write", 1, 0, 0);
    check("ch2 ch_data", bus_if.ch_data, 64'h0000_BEEF_0000_0000);

    // Back-to-back frames to ch1.
    send_bits(32'h010001, 24);
    end_frame("b2b first", 1, 0, 0);
    send_bits(32'h010002, 24);
    end_frame("b2b second", 1, 0, 0);
    check("b2b ch_data", bus_if.ch_data, 64'h0000_BEEF_0002_0000);

    // Readback: ch2 = 1234, then overwrite with FFFF while reading old value.
    send_bits(32'h021234, 24);
    end_frame("rb preload", 1, 0, 0);
    send_bits(32'h02FFFF, 24);
`ifdef SPI_READBACK_EN
    check("rb sdo stream", 64'(sdo_cap), 64'h1234);
`else
    check("rb sdo stream", 64'(sdo_cap), 64'h0000);
`endif
    end_frame("rb write", 1, 0, 0);
    check("rb ch_data", bus_if.ch_data, 64'h0000_FFFF_0002_0000);
    check("rb idle sdo", 64'(bus_if.sdo), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
